// File: rtl/inst_fetcher.sv
// Instruction fetcher: assembles a 32-bit little-endian word from four byte reads and pushes it with its PC.
// Optional direct-mapped instruction cache is enabled by defining FETCHER_ICACHE_EN.
module inst_fetcher #(
  parameter int ADDR_W       = 32,
  parameter int ICACHE_LINES = 64
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_rdy,
  input  logic              in_pc_enable,
  input  logic [ADDR_W-1:0] in_pc,
  output logic              out_pc_stall,
  input  logic              in_flush_enable,
  output logic [ADDR_W-1:0] out_ram_addr,
  input  logic [7:0]        in_ram_data,
  input  logic              in_iq_full,
  output logic              out_inst_valid,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_inst_pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PUSH  = 2'd2
  } state_t;

  localparam int IDX_W = $clog2(ICACHE_LINES);

  if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_lines_check
    $error("ICACHE_LINES must be a power of two and at least 2");
  end

  state_t      state;
  logic [2:0]  cnt;
  logic        hit;
  logic [31:0] hit_data;
  logic        fill;

  // Stall also covers the acceptance cycle itself, since in_pc_enable is part of it.
  assign out_pc_stall = (state != IDLE) | in_pc_enable | in_iq_full | in_flush_enable;

  assign fill = (state == FETCH) && (cnt == 3'd4) && !in_flush_enable;

`ifdef FETCHER_ICACHE_EN
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [31:0]       c_data [ICACHE_LINES];
  logic [TAG_W-1:0]  c_tag  [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] c_valid;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  fill_idx;

  assign req_idx  = in_pc[IDX_W+1:2];
  assign fill_idx = out_inst_pc[IDX_W+1:2];
  assign hit      = c_valid[req_idx] && (c_tag[req_idx] == in_pc[ADDR_W-1:IDX_W+2]);
  assign hit_data = c_data[req_idx];

  // Line valid bits: cleared by reset only, set when a RAM fetch completes.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      c_valid <= '0;
    end else if (in_rdy && fill) begin
      c_valid[fill_idx] <= 1'b1;
    end
  end

  // Line payload and tag written from the completing fetch (top byte comes straight from RAM).
  always_ff @(posedge in_clk) begin
    if (!in_rst && in_rdy && fill) begin
      c_data[fill_idx] <= {in_ram_data, out_inst[23:0]};
      c_tag[fill_idx]  <= out_inst_pc[ADDR_W-1:IDX_W+2];
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = 32'd0;
`endif

  // Fetch sequencer: flush outranks everything; in_rdy low freezes all state.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state          <= IDLE;
      cnt            <= 3'd0;
      out_inst_valid <= 1'b0;
      out_inst       <= 32'd0;
      out_inst_pc    <= '0;
      out_ram_addr   <= '0;
    end else if (in_rdy) begin
      out_inst_valid <= 1'b0;
      if (in_flush_enable) begin
        state <= IDLE;
        cnt   <= 3'd0;
      end else begin
        case (state)
          IDLE: begin
            if (in_pc_enable) begin
              out_inst_pc <= in_pc;
              if (hit) begin
                out_inst <= hit_data;
                if (in_iq_full) begin
                  state <= PUSH;
                end else begin
                  out_inst_valid <= 1'b1;
                end
              end else begin
                out_ram_addr <= in_pc;
                cnt          <= 3'd0;
                state        <= FETCH;
              end
            end
          end
          FETCH: begin
            cnt <= cnt + 3'd1;
            if (cnt < 3'd3) begin
              out_ram_addr <= out_ram_addr + ADDR_W'(1);
            end
            // Byte returned now belongs to the address driven one cycle earlier.
            case (cnt)
              3'd1:    out_inst[7:0]   <= in_ram_data;
              3'd2:    out_inst[15:8]  <= in_ram_data;
              3'd3:    out_inst[23:16] <= in_ram_data;
              3'd4:    out_inst[31:24] <= in_ram_data;
              default: ;
            endcase
            if (cnt == 3'd4) begin
              cnt <= 3'd0;
              if (in_iq_full) begin
                state <= PUSH;
              end else begin
                out_inst_valid <= 1'b1;
                state          <= IDLE;
              end
            end
          end
          PUSH: begin
            if (!in_iq_full) begin
              out_inst_valid <= 1'b1;
              state          <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= 3'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher: directed scenarios plus randomized fetches against a byte-array RAM model.
// Cache expectations apply when FETCHER_ICACHE_EN is defined.
module tb_inst_fetcher;

  localparam int ADDR_W = 32;
  localparam int LINES  = 64;

  logic              in_clk = 1'b0;
  logic              in_rst = 1'b1;
  logic              in_rdy = 1'b1;
  logic              in_pc_enable = 1'b0;
  logic [ADDR_W-1:0] in_pc = '0;
  logic              out_pc_stall;
  logic              in_flush_enable = 1'b0;
  logic [ADDR_W-1:0] out_ram_addr;
  logic [7:0]        in_ram_data = 8'd0;
  logic              in_iq_full = 1'b0;
  logic              out_inst_valid;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_inst_pc;

  int checks = 0;
  int errors = 0;

  logic [7:0]        mem [256];
  logic [ADDR_W-1:0] prev_addr = '0;
  bit                line_valid [LINES];
  logic [ADDR_W-1:0] line_pc    [LINES];

  inst_fetcher #(.ADDR_W(ADDR_W), .ICACHE_LINES(LINES)) dut (
    .in_clk          (in_clk),
    .in_rst          (in_rst),
    .in_rdy          (in_rdy),
    .in_pc_enable    (in_pc_enable),
    .in_pc           (in_pc),
    .out_pc_stall    (out_pc_stall),
    .in_flush_enable (in_flush_enable),
    .out_ram_addr    (out_ram_addr),
    .in_ram_data     (in_ram_data),
    .in_iq_full      (in_iq_full),
    .out_inst_valid  (out_inst_valid),
    .out_inst        (out_inst),
    .out_inst_pc     (out_inst_pc)
  );

  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; the RAM answers the address of the previous cycle when in_rdy was high.
  task automatic step();
    @(negedge in_clk);
    if (in_rdy) in_ram_data = mem[prev_addr[7:0]];
    prev_addr = out_ram_addr;
  endtask

  task automatic clear_model();
    for (int i = 0; i < LINES; i++) line_valid[i] = 1'b0;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      in_pc_enable = 1'b0; in_iq_full = 1'b0; in_flush_enable = 1'b0; in_rdy = 1'b1;
      #1;
      check("idle_valid", 64'(out_inst_valid), 64'd0);
      check("idle_stall", 64'(out_pc_stall), 64'd0);
    end
  endtask

  // One request issued in the current cycle; rdy gap covers cycles [rdy_at, rdy_at+rdy_len), full is held rdy-free for full_len cycles at completion.
  task automatic fetch(input logic [ADDR_W-1:0] pc, input int rdy_at, input int rdy_len_i, input int full_len_i);
    logic [31:0] exp_inst;
    bit hit;
    int idx, vcyc, eff, rdy_len, full_len;
    exp_inst = {mem[8'(pc + 32'd3)], mem[8'(pc + 32'd2)], mem[8'(pc + 32'd1)], mem[8'(pc)]};
    idx = int'((pc >> 2) % LINES);
    hit = 1'b0;
`ifdef FETCHER_ICACHE_EN
    hit = line_valid[idx] && (line_pc[idx] == pc);
`endif
    rdy_len  = hit ? 0 : rdy_len_i;
    full_len = hit ? 0 : full_len_i;
    vcyc = hit ? 1 : 6 + rdy_len + full_len;

    in_pc = pc; in_pc_enable = 1'b1; in_rdy = 1'b1; in_iq_full = 1'b0; in_flush_enable = 1'b0;
    #1;
    check("accept_stall", 64'(out_pc_stall), 64'd1);
    eff = 0;
    for (int k = 1; k <= vcyc; k++) begin
      if (k > 1 && in_rdy) eff++;
      step();
      in_pc_enable = 1'b0;
      in_pc = $urandom;
      in_rdy = !(rdy_len > 0 && k >= rdy_at && k < rdy_at + rdy_len);
      in_iq_full = (full_len > 0 && k >= 5 + rdy_len && k < 5 + rdy_len + full_len);
      #1;
      if (k < vcyc) begin
        check("wait_valid", 64'(out_inst_valid), 64'd0);
        check("wait_stall", 64'(out_pc_stall), 64'd1);
        if (!hit && eff <= 3) check("ram_addr", 64'(out_ram_addr), 64'(pc + ADDR_W'(eff)));
      end else begin
        check("valid", 64'(out_inst_valid), 64'd1);
        check("inst", 64'(out_inst), 64'(exp_inst));
        check("inst_pc", 64'(out_inst_pc), 64'(pc));
        check("done_stall", 64'(out_pc_stall), 64'd0);
      end
    end
    if (!hit) begin
      line_valid[idx] = 1'b1;
      line_pc[idx]    = pc;
    end
  endtask

  initial begin
    int ra, rl, fl;
    logic [ADDR_W-1:0] rpc;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
    clear_model();

    // Reset state
    for (int i = 0; i < 3; i++) step();
    in_rst = 1'b0;
    #1;
    check("rst_valid", 64'(out_inst_valid), 64'd0);
    check("rst_inst", 64'(out_inst), 64'd0);
    check("rst_inst_pc", 64'(out_inst_pc), 64'd0);
    check("rst_ram_addr", 64'(out_ram_addr), 64'd0);
    check("rst_stall", 64'(out_pc_stall), 64'd0);
    idle_check(2);

    // Known instruction at pc 0, then back-to-back 0x4 issued in the valid cycle
    fetch(32'h0, 1, 0, 0);
    check("known_word", 64'(out_inst), 64'h0000_0000_0010_0513);
    fetch(32'h4, 1, 0, 0);
    idle_check(2);

    // Queue full for 3 cycles at completion
    fetch(32'h20, 1, 0, 3);
    idle_check(2);

    // Ready gap of 2 cycles during FETCH
    fetch(32'h30, 2, 2, 0);
    idle_check(1);

    // Top of address space
    fetch(32'hFFFF_FFFC, 1, 0, 0);
    idle_check(1);

    // Flush at C3 of pc 0x8, then branch target 0x40
    in_pc = 32'h8; in_pc_enable = 1'b1;
    step(); in_pc_enable = 1'b0;
    step();
    step(); in_flush_enable = 1'b1;
    #1;
    check("flush_stall", 64'(out_pc_stall), 64'd1);
    step(); in_flush_enable = 1'b0;
    #1;
    check("post_flush_valid", 64'(out_inst_valid), 64'd0);
    check("post_flush_stall", 64'(out_pc_stall), 64'd0);
    idle_check(6);
    fetch(32'h40, 1, 0, 0);
    idle_check(1);

    // Enable together with flush in IDLE is ignored
    in_pc = 32'h50; in_pc_enable = 1'b1; in_flush_enable = 1'b1;
    step(); in_pc_enable = 1'b0; in_flush_enable = 1'b0;
    #1;
    check("flush_en_stall", 64'(out_pc_stall), 64'd0);
    idle_check(7);

    // Reset in the middle of a fetch
    in_pc = 32'h60; in_pc_enable = 1'b1;
    step(); in_pc_enable = 1'b0;
    step(); in_rst = 1'b1;
    step(); in_rst = 1'b0;
    clear_model();
    #1;
    check("midrst_inst", 64'(out_inst), 64'd0);
    check("midrst_ram_addr", 64'(out_ram_addr), 64'd0);
    check("midrst_inst_pc", 64'(out_inst_pc), 64'd0);
    idle_check(7);

    // Cache scenario: same pc twice, then a tag conflict on the same line
    fetch(32'h10, 1, 0, 0);
    fetch(32'h10, 1, 0, 0);
    fetch(32'h10 + 32'(4 * LINES), 1, 0, 0);
    idle_check(1);

    // Randomized fetches
    for (int n = 0; n < 24; n++) begin
      rpc = $urandom & 32'hFFFF_FFFC;
      if (n % 4 == 3) rpc = 32'h10;
      ra = $urandom_range(1, 4);
      rl = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      fl = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 4) : 0;
      fetch(rpc, ra, rl, fl);
      idle_check($urandom_range(1, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Consumer end of the PC-address interface: takes the fetch PC and enable pulse from the PC controller.
- Reads the instruction from byte-wide instruction RAM in four sequential byte reads and assembles a 32-bit little-endian instruction.
- Pushes the instruction plus its PC to the instruction queue.
- Back-pressures the PC controller with a stall while busy, and aborts on ROB flush.

Parameters:
ADDR_W, 32, width of PC and RAM address
ICACHE_LINES, 64, direct-mapped cache entries (power of two; used only with the optional feature)

Ports:
in_clk  input  1  clock; all state updates on posedge
in_rst  input  1  synchronous reset, active-high
in_rdy  input  1  global ready; low freezes all state (outputs hold)
in_pc_enable  input  1  fetch request from PC controller
in_pc  input  ADDR_W  fetch address (word aligned)
out_pc_stall  output  1  stall to PC controller (combinational)
in_flush_enable  input  1  ROB misprediction flush
out_ram_addr  output  ADDR_W  byte address to instruction RAM
in_ram_data  input  8  RAM read data; 1-cycle latency after address
in_iq_full  input  1  instruction queue cannot accept
out_inst_valid  output  1  instruction push strobe (one cycle per instruction)
out_inst  output  32  assembled instruction
out_inst_pc  output  ADDR_W  PC of out_inst

Behaviour:
- Reset values: state=IDLE, byte counter=0, out_inst_valid=0, out_inst=0, out_inst_pc=0, out_ram_addr=0.
- Register updates occur only on edges with in_rdy=1; otherwise all registers hold.
- States: IDLE, FETCH, PUSH.
- IDLE:
  - If in_pc_enable=1 and in_flush_enable=0: latch in_pc, set out_ram_addr<=in_pc, cnt<=0, go to FETCH.
- FETCH:
  - Addresses pc, pc+1, pc+2, pc+3 are driven on cycles C1..C4.
  - The byte for the address driven in Ck is sampled at the end of Ck+1 and placed in inst[8k-1:8k-8].
  - The last byte is sampled at the end of C5. At that edge: if in_iq_full=0, out_inst_valid<=1 and go to IDLE; else go to PUSH.
  - Latency: enable sampled at edge E -> out_inst_valid high in the 6th cycle after E.
- PUSH:
  - Hold the assembled word.
  - At the first edge with in_iq_full=0: out_inst_valid<=1, go to IDLE.
- out_inst_valid:
  - High for exactly one cycle per instruction; otherwise 0.
  - out_inst and out_inst_pc are stable while valid.
- out_pc_stall = (state!=IDLE) | in_pc_enable | in_iq_full | in_flush_enable. This guarantees no PC is issued while a request is in flight, including on the acceptance cycle.
- Flush has priority over everything:
  - At an edge with in_flush_enable=1: state<=IDLE, out_inst_valid<=0, partial bytes discarded, in_pc_enable ignored.
  - The next accepted enable carries the branch PC.
- Reset mid-fetch: identical to reset; no instruction is pushed.
- Address arithmetic is ADDR_W-bit modulo; pc=0xFFFFFFFC reads bytes 0xFFFFFFFC..0xFFFFFFFF with no wrap issue. A pc+3 overflow wraps silently.
- in_pc_enable while not IDLE is illegal (the stall forbids it) and is ignored.

Optional Feature:
FETCHER_ICACHE_EN
- Defined:
  - Direct-mapped instruction cache of ICACHE_LINES words.
  - Index = pc[log2(ICACHE_LINES)+1:2]; tag = remaining upper bits; one valid bit per line.
  - Hit in IDLE on accepted enable:
    - If in_iq_full=0: out_inst_valid<=1 at the same edge, so the instruction appears in the cycle after acceptance.
    - If in_iq_full=1: go to PUSH.
  - Miss: normal FETCH; on completion, write the line.
  - Reset clears all valid bits; flush does not invalidate the cache.
- Undefined: no cache storage; every request takes the 5-cycle RAM path.

Test Plan:
- Reset, then pc=0x00 enable with RAM bytes 0x13,0x05,0x10,0x00 -> out_inst=0x00100513, out_inst_pc=0x0, valid 6 cycles after enable; out_ram_addr sequence 0,1,2,3.
- Back-to-back: PC controller behaviour modelled, pcs 0x0 then 0x4 -> two pushes; second out_inst_pc=0x4; out_pc_stall high from acceptance until return to IDLE; no request lost.
- in_iq_full=1 at fetch completion, held 3 cycles -> PUSH state, valid asserted at the edge after full drops, exactly one pulse with unchanged data.
- Flush at C3 of pc=0x8 fetch, then enable with pc=0x40 -> no push for 0x8; next push has out_inst_pc=0x40.
- in_rdy low for 2 cycles during FETCH -> addresses and counter hold; assembled word correct; latency extended by exactly 2.
- With FETCHER_ICACHE_EN: fetch 0x10 twice -> second access valid 1 cycle after acceptance with no RAM reads. Then fetch 0x10+4*ICACHE_LINES -> miss (tag conflict), 5-cycle path.
